nmea_lat_tx: RTL

Serializes a four-digit BCD latitude field into an ASCII NMEA-style sentence, `$GPLAT,dddd*hh<CR><LF>`. The sentence is emitted one byte at a time over a valid/ready byte stream that feeds the UART transmitter. The block is the transmit-side counterpart of the latitude extraction path: BCD digits go in and ASCII characters come out, with the XOR checksum generated on the fly. It is used for loopback testing and for re-broadcasting the current fix.

---
 rtl/nmea_lat_tx_if.sv | 9 +
 rtl/nmea_lat_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/nmea_lat_tx_if.sv
// rtl/nmea_lat_tx_if.sv - byte stream from the latitude sentence serializer to the UART transmitter
interface nmea_lat_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/nmea_lat_tx.sv
// rtl/nmea_lat_tx.sv - BCD latitude to "$GPLAT,dddd*hh\r\n" ASCII sentence serializer
// Optional checksum ("*hh" plus accumulator) enabled by NMEA_LAT_TX_CHECKSUM_EN.
module nmea_lat_tx (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       d0,
  input  logic [3:0]       d1,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  nmea_lat_tx_if.master    tx,
  output logic             busy,
  output logic             done,
  output logic             digit_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

`ifdef NMEA_LAT_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd15;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  dig [4];
  logic [7:0]  byte_at;
  logic        accept;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h2D : {4'h3, d};
  endfunction

`ifdef NMEA_LAT_TX_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n > 4'd9) ? (8'h41 + {4'h0, n} - 8'd10) : {4'h3, n};
  endfunction
`endif

  assign accept = (state == S_SEND) && tx.tx_ready;

  always_comb begin
    byte_at = 8'h00;
    case (idx)
      4'd0:  byte_at = 8'h24;
      4'd1:  byte_at = 8'h47;
      4'd2:  byte_at = 8'h50;
      4'd3:  byte_at = 8'h4C;
      4'd4:  byte_at = 8'h41;
      4'd5:  byte_at = 8'h54;
      4'd6:  byte_at = 8'h2C;
      4'd7:  byte_at = digit_char(dig[0]);
      4'd8:  byte_at = digit_char(dig[1]);
      4'd9:  byte_at = digit_char(dig[2]);
      4'd10: byte_at = digit_char(dig[3]);
`ifdef NMEA_LAT_TX_CHECKSUM_EN
      4'd11: byte_at = 8'h2A;
      4'd12: byte_at = hex_char(csum[7:4]);
      4'd13: byte_at = hex_char(csum[3:0]);
      4'd14: byte_at = 8'h0D;
      4'd15: byte_at = 8'h0A;
`else
      4'd11: byte_at = 8'h0D;
      4'd12: byte_at = 8'h0A;
`endif
      default: byte_at = 8'h00;
    endcase
  end

  // Outputs decode straight from state so the async reset clears them at once.
  assign tx.tx_valid = (state == S_SEND);
  assign tx.tx_data  = (state == S_SEND) ? byte_at : 8'h00;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      digit_err <= 1'b0;
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dig[0]    <= d0;
            dig[1]    <= d1;
            dig[2]    <= d2;
            dig[3]    <= d3;
            idx       <= 4'd0;
            digit_err <= (d0 > 4'd9) | (d1 > 4'd9) | (d2 > 4'd9) | (d3 > 4'd9);
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state <= S_FIN;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NMEA_LAT_TX_CHECKSUM_EN
  // Bytes 1..10 lie strictly between '$' and '*'; the hex bytes read the finished sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (state == S_IDLE && start) begin
      csum <= 8'h00;
    end else if (accept && idx >= 4'd1 && idx <= 4'd10) begin
      csum <= csum ^ byte_at;
    end
  end
`endif

endmodule
